// File: rtl/alu_exec_if.sv
// Instruction handshake bundle between a requester and the ALU execute sequencer.
interface alu_exec_if #(
    parameter int WIDTH = 8
) ();
    logic             instr_valid;
    logic             instr_ready;
    logic             instr_load;
    logic [2:0]       instr_op;
    logic [1:0]       instr_rd;
    logic [1:0]       instr_rs;
    logic [WIDTH-1:0] instr_imm;

    modport master (
        output instr_valid, instr_load, instr_op, instr_rd, instr_rs, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_load, instr_op, instr_rd, instr_rs, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage sequencer for an external ALU8: register file, operand/op registers,
// result and flag write-back.
//   state | meaning
//   IDLE  | ready for an instruction
//   EXEC  | operands held on alu_a/alu_b, ALU8 settling
//   WB    | instruction retired, done asserted
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_if.slave        instr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic [3:0]       flags,
    output logic             done,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [1:0]       rd_q, rd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            flags_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            rd_q     <= rd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        flags_d  = flags_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        rd_d     = rd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (instr.instr_valid) begin
                    if (instr.instr_load) begin
                        // Loads bypass the ALU entirely; operand and flag registers keep their values.
                        regs_d[instr.instr_rd] = instr.instr_imm;
                        state_d                = ST_WB;
                    end else begin
                        alu_a_d  = regs_q[instr.instr_rd];
                        alu_b_d  = regs_q[instr.instr_rs];
                        alu_op_d = instr.instr_op;
                        rd_d     = instr.instr_rd;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                regs_d[rd_q] = alu_result;
                flags_d      = {alu_n, alu_z, alu_v, alu_c};
                state_d      = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign instr.instr_ready = (state_q == ST_IDLE);
    assign done              = (state_q == ST_WB);
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign alu_op            = alu_op_q;
    assign flags             = flags_q;
    assign dbg_data          = regs_q[dbg_sel];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit with a behavioural ALU8 stand-in and register-file model.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(8)) bus ();

    logic [7:0] alu_a, alu_b, alu_result, dbg_data;
    logic [2:0] alu_op;
    logic       alu_n, alu_z, alu_v, alu_c, done;
    logic [3:0] flags;
    logic [1:0] dbg_sel, mon_sel, chk_sel;
    logic       mon_active;

    assign dbg_sel = mon_active ? mon_sel : chk_sel;

    alu_exec_unit #(.WIDTH(8), .NREGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c),
        .flags(flags), .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // ALU8 behaviour from integer arithmetic: returns {result, N, Z, V, C}; C is carry for add, borrow for subtract.
    function automatic logic [11:0] alu8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int ai, rhs, r, sa, srhs, sr;
        logic [7:0] res;
        logic v, c;
        ai = int'(a);
        v = 1'b0;
        c = 1'b0;
        rhs = (op == 3'd1 || op == 3'd3) ? 1 : int'(b);
        sa = (ai >= 128) ? ai - 256 : ai;
        srhs = (rhs >= 128) ? rhs - 256 : rhs;
        case (op)
            3'd0, 3'd1: begin
                r = ai + rhs; c = (r > 255); sr = sa + srhs; v = (sr > 127) || (sr < -128);
                res = r[7:0];
            end
            3'd2, 3'd3: begin
                r = ai - rhs; c = (ai < rhs); sr = sa - srhs; v = (sr > 127) || (sr < -128);
                res = r[7:0];
            end
            3'd4: res = a & b;
            3'd5: res = a | b;
            3'd6: res = a ^ b;
            default: res = ~a;
        endcase
        return {res, res[7], (res == 8'h00), v, c};
    endfunction

    assign {alu_result, alu_n, alu_z, alu_v, alu_c} = alu8(alu_op, alu_a, alu_b);

    typedef struct {
        logic [1:0] rd;
        logic [7:0] val;
        logic [3:0] fl;
        logic [2:0] op;
        bit         ld;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_regs [4];
    logic [3:0] m_flags;
    logic [2:0] m_op;
    int         cyc = 0;
    int         acc_q = 0;
    int         busy_q = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'h0;
        m_op = 3'd0;
        sb.delete();
        acc_q = 0;
        busy_q = 0;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit ld, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input bit keep_valid);
        int guard;
        logic [11:0] r;
        exp_t e;
        bus.instr_valid = 1'b1;
        bus.instr_load  = ld;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs    = rs;
        bus.instr_imm   = imm;
        guard = 0;
        while (!bus.instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            chk("accept_timeout", 0, 1);
            bus.instr_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        e.rd = rd;
        e.ld = ld;
        if (ld) begin
            m_regs[rd] = imm;
            busy_q = e.acc + 1;
        end else begin
            r = alu8(op, m_regs[rd], m_regs[rs]);
            m_regs[rd] = r[11:4];
            m_flags = r[3:0];
            m_op = op;
            busy_q = e.acc + 2;
        end
        acc_q = e.acc;
        e.val = m_regs[rd];
        e.fl = m_flags;
        e.op = m_op;
        sb.push_back(e);
        @(negedge clk);
        if (!keep_valid) bus.instr_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ready"}, int'(bus.instr_ready), 1);
        chk({tag, "_flags"}, int'(flags), 0);
        chk({tag, "_alu_op"}, int'(alu_op), 0);
        for (int i = 0; i < 4; i++) begin
            chk_sel = 2'(i);
            #1;
            chk({tag, "_reg"}, int'(dbg_data), 0);
        end
    endtask

    task automatic sweep_regs();
        for (int i = 0; i < 4; i++) begin
            chk_sel = 2'(i);
            #1;
            chk("reg_sweep", int'(dbg_data), int'(m_regs[i]));
        end
    endtask

    // Monitor: ready shape every cycle, and a scoreboard pop on every done.
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_sel = 2'd0;
        forever begin
            @(negedge clk);
            #1;
            chk("ready", int'(bus.instr_ready), (cyc >= acc_q && cyc < busy_q) ? 0 : 1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    mon_active = 1'b1;
                    mon_sel = e.rd;
                    #1;
                    chk("done_latency", cyc, e.acc + (e.ld ? 0 : 1));
                    chk("rd_value", int'(dbg_data), int'(e.val));
                    chk("flags", int'(flags), int'(e.fl));
                    chk("alu_op", int'(alu_op), int'(e.op));
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bus.instr_valid = 1'b0;
        bus.instr_load  = 1'b0;
        bus.instr_op    = 3'd0;
        bus.instr_rd    = 2'd0;
        bus.instr_rs    = 2'd0;
        bus.instr_imm   = 8'h00;
        chk_sel = 2'd0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD overflow into the sign bit
        issue(1, 3'd0, 2'd0, 2'd0, 8'h7F, 0);
        issue(1, 3'd0, 2'd1, 2'd0, 8'h01, 0);
        issue(0, 3'd0, 2'd0, 2'd1, 8'h00, 0);
        @(negedge clk);
        // SUB rd==rs, then DEC from zero
        issue(1, 3'd0, 2'd2, 2'd0, 8'h05, 0);
        issue(0, 3'd2, 2'd2, 2'd2, 8'h00, 0);
        issue(0, 3'd3, 2'd3, 2'd0, 8'h00, 0);
        // ALU op then load: flags and alu_op must hold
        issue(0, 3'd0, 2'd0, 2'd1, 8'h00, 0);
        issue(1, 3'd0, 2'd2, 2'd0, 8'h00, 0);
        // Back-to-back XOR then NOT with valid held high
        issue(1, 3'd0, 2'd0, 2'd0, 8'hF0, 0);
        issue(1, 3'd0, 2'd1, 2'd0, 8'h0F, 0);
        issue(0, 3'd6, 2'd0, 2'd1, 8'h00, 1);
        issue(0, 3'd7, 2'd0, 2'd0, 8'h00, 0);
        repeat (3) @(negedge clk);
        sweep_regs();
        @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            gap = int'($urandom_range(0, 2));
            issue(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), (gap == 0));
            repeat (gap) @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        sweep_regs();

        // Mid-run reset with non-zero state
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        reset_checks("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort during EXEC of INC r0
        issue(1, 3'd0, 2'd0, 2'd0, 8'h10, 0);
        issue(0, 3'd1, 2'd0, 2'd1, 8'h00, 0);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        reset_checks("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        sweep_regs();
        chk("post_abort_flags", int'(flags), 0);
        chk("post_abort_queue", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage sequencer and register file that sits directly in front of and behind the 8-bit ALU (ALU8). It accepts one instruction at a time over a valid/ready handshake and drives ALU8's `a`, `b` and `operation` inputs from a 4×8 register file. It captures ALU8's result and N/Z/V/C flags back into the register file and a flags register. ALU8 is instantiated beside this block by the parent, not inside it.

## Interface
Parameters:
- `WIDTH`, default 8: data width. Must be 8 to match ALU8.
- `NREGS`, default 4: register count. Fixed at 4 by the 2-bit indices.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  block can accept an instruction.
- `instr_load`  in  1  1 = load immediate into rd (no ALU op); 0 = ALU op.
- `instr_op`  in  3  ALU operation: ADD 000, INC 001, SUB 010, DEC 011, AND 100, OR 101, XOR 110, NOT 111.
- `instr_rd`  in  2  destination register and operand A.
- `instr_rs`  in  2  operand B register.
- `instr_imm`  in  8  immediate value for load.
- `alu_a`  out  8  to ALU8 `a`.
- `alu_b`  out  8  to ALU8 `b`.
- `alu_op`  out  3  to ALU8 `operation`.
- `alu_result`  in  8  from ALU8 `result`.
- `alu_n`, `alu_z`, `alu_v`, `alu_c`  in  1 each  from ALU8 flags.
- `flags`  out  4  registered {N,Z,V,C}.
- `done`  out  1  one-cycle pulse: instruction retired.
- `dbg_sel`  in  2  debug read index.
- `dbg_data`  out  8  combinational read of reg[dbg_sel].

## Operation
- FSM states: IDLE, EXEC, WB.
- **IDLE** (`instr_ready`=1):
  - On `instr_valid`=1 and load=0: latch `alu_a`←reg[rd], `alu_b`←reg[rs], `alu_op`←`instr_op`, latch rd; go to EXEC.
  - On `instr_valid`=1 and load=1: write reg[rd]←`instr_imm` on the accept edge; go to WB. Flags and `alu_*` are unchanged.
- **EXEC** (ready=0): ALU8 computes combinationally. On the edge leaving EXEC: reg[rd]←`alu_result`, `flags`←{`alu_n`,`alu_z`,`alu_v`,`alu_c`}; go to WB.
- **WB** (ready=0, `done`=1): go to IDLE on the next edge.
- rd==rs is legal; both operands take the same pre-instruction value.
- Unary ops (INC, DEC, NOT) still drive `alu_b`; ALU8 ignores it.
- Every ALU op writes all four flags, including logic ops, for which ALU8 supplies V=C=0.
- `alu_a`, `alu_b` and `alu_op` are registers. They change only on ALU-op acceptance and hold their values otherwise.
- Requester handshake: it holds `instr_valid` and all instruction fields stable until accepted. Valid while ready=0 is ignored.
- Reset values: all registers 0x00, `flags`=0000, `alu_a`=`alu_b`=0x00, `alu_op`=000, state IDLE (`instr_ready`=1), `done`=0.
- Reset asserted mid-instruction (EXEC or WB) aborts it. No write-back, no `done`, everything returns to reset values.

## Timing
- ALU op: accept at edge T. EXEC during cycle T..T+1. Write-back at edge T+1. `done`=1 and new reg/flags visible during cycle T+1..T+2. Ready again at T+2.
- ALU-op throughput: 1 instruction per 3 cycles.
- Load: write at accept edge T. `done` high cycle T..T+1. Ready at T+1.
- Load throughput: 1 instruction per 2 cycles.
- Combinational path through ALU8 is bounded by one EXEC cycle. The block introduces no combinational path from `alu_*` inputs to any output.
- `dbg_data` reflects a write in the cycle after the write edge.

## Test plan
- Reset: drive rst_n low mid-run, then release -> `dbg_data`=0x00 for all 4 regs, `flags`=0000, `instr_ready`=1, `done`=0, `alu_op`=000.
- Load r0=0x7F, load r1=0x01, ADD rd=0 rs=1 -> r0=0x80, `flags`=1010 (N=1, V=1). `done` pulses exactly one cycle, 1 cycle after ADD accept. Ready low for 2 cycles.
- Load r2=0x05, SUB rd=2 rs=2 -> r2=0x00, `flags`=0100. Then DEC rd=3 (r3=0x00) -> r3=0xFF, `flags`=1001.
- After the ADD above, load r2=0x00 -> `flags` stays 1010, `done` 1 cycle after accept, `alu_op` stays 000.
- Back-to-back: `instr_valid` held high with XOR r0,r1 (0xF0, 0x0F) then NOT r0 -> second accepted on the cycle `done` falls. r0=0xFF then 0x00. `flags`=1000 then 0100.
- Abort: assert rst_n during EXEC of INC r0 (r0=0x10) -> no `done`, r0=0x00 after reset, `flags`=0000.
